// File: rtl/gal_cfg_pkg.sv
// ----------------------------------------------------------------------------
// gal_cfg_pkg
// Shared definitions for the GAL fuse loader. It holds the loader state
// encoding, the ERR_CODE values and the helpers that derive the fuse and byte
// counts of a JEDEC stream from the AND-array geometry.
// ----------------------------------------------------------------------------
package gal_cfg_pkg;

   // The loader walks IDLE -> LOAD -> CHECK -> OK/FAIL. OK and FAIL are
   // parking states that only a new START leaves.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CHECK,
      ST_OK,
      ST_FAIL
   } state_t;

   // These values appear on ERR_CODE once a load has failed.
   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_SHORT = 2'd1;
   localparam logic [1:0] ERR_LONG  = 2'd2;
   localparam logic [1:0] ERR_CKSUM = 2'd3;

   // Every row holds two fuses per input, and two OLMC mode fuses follow the
   // last row.
   function automatic int nfuse(input int width, input int depth);
      return 2 * width * depth + 2;
   endfunction

   // The stream is padded up to a whole number of bytes.
   function automatic int nbytes(input int width, input int depth);
      return (nfuse(width, depth) + 7) / 8;
   endfunction

endpackage

// File: rtl/gal_fuse_loader_if.sv
// ----------------------------------------------------------------------------
// gal_fuse_loader_if
// Byte stream that carries the JEDEC fuse image into the loader.
//   S_VALID  source has a fuse byte on S_DATA
//   S_READY  loader accepts the byte this cycle
//   S_DATA   fuse byte, bit 0 = lowest fuse index
//   S_LAST   marks the final byte of the stream
// The programmer drives the master modport and the loader uses the slave
// modport.
// ----------------------------------------------------------------------------
interface gal_fuse_loader_if;

   logic       S_VALID;
   logic       S_READY;
   logic [7:0] S_DATA;
   logic       S_LAST;

   modport master (
      output S_VALID,
      output S_DATA,
      output S_LAST,
      input  S_READY
   );

   modport slave (
      input  S_VALID,
      input  S_DATA,
      input  S_LAST,
      output S_READY
   );

endinterface

// File: rtl/gal_fuse_rowbuf.sv
// ----------------------------------------------------------------------------
// gal_fuse_rowbuf
// Collects fuse bytes into AND-array rows of 2*WIDTH bits. The block emits one
// registered write for each completed row, and it stops after DEPTH rows so
// that mode and pad fuses never reach the product-term table.
//   clk, rst_n   clock and asynchronous active-low reset
//   i_clear      drop all progress (new load)
//   i_push       an accepted fuse byte is on i_data
//   i_data       fuse byte, bit 0 = lowest fuse
//   o_rowWe      one-cycle row write strobe
//   o_rowAddr    row index for the write
//   o_rowData    row fuses, bit 0 = lowest fuse of the row
// ----------------------------------------------------------------------------
module gal_fuse_rowbuf #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_clear,
   input  logic                     i_push,
   input  logic [7:0]               i_data,
   output logic                     o_rowWe,
   output logic [$clog2(DEPTH)-1:0] o_rowAddr,
   output logic [2*WIDTH-1:0]       o_rowData
);

   localparam int RW = 2 * WIDTH;
   localparam int BW = RW + 8;
   localparam int FW = $clog2(RW + 8);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [BW-1:0]    r_buf;
   logic [FW-1:0]    r_fill;
   logic [CW-1:0]    r_rowCnt;
   logic             r_rowWe;
   logic [AW-1:0]    r_rowAddr;
   logic [RW-1:0]    r_rowData;

   logic [BW-1:0]    w_merged;
   logic [FW-1:0]    w_sumFill;
   logic             w_rowDone;
   logic             w_haveRoom;

   // The incoming byte lands directly above the bits already held. The buffer
   // always holds fewer than RW bits, and RW is at least 8, so one byte can
   // finish at most one row. Any bits left over start the next row.
   assign w_merged   = r_buf | (BW'(i_data) << r_fill);
   assign w_sumFill  = r_fill + FW'(8);
   assign w_rowDone  = (w_sumFill >= FW'(RW));
   assign w_haveRoom = (r_rowCnt < CW'(DEPTH));

   // Accumulate bits and register a row write when a row fills. When all
   // DEPTH rows are written, later bits still shift through the buffer, but
   // the block writes no more rows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf     <= '0;
         r_fill    <= '0;
         r_rowCnt  <= '0;
         r_rowWe   <= 1'b0;
         r_rowAddr <= '0;
         r_rowData <= '0;
      end else if (i_clear) begin
         r_buf     <= '0;
         r_fill    <= '0;
         r_rowCnt  <= '0;
         r_rowWe   <= 1'b0;
         r_rowAddr <= '0;
         r_rowData <= '0;
      end else begin
         r_rowWe <= 1'b0;
         if (i_push) begin
            if (w_rowDone) begin
               r_buf  <= w_merged >> RW;
               r_fill <= w_sumFill - FW'(RW);
               if (w_haveRoom) begin
                  r_rowWe   <= 1'b1;
                  r_rowAddr <= r_rowCnt[AW-1:0];
                  r_rowData <= w_merged[RW-1:0];
                  r_rowCnt  <= r_rowCnt + CW'(1);
               end
            end else begin
               r_buf  <= w_merged;
               r_fill <= w_sumFill;
            end
         end
      end
   end

   assign o_rowWe   = r_rowWe;
   assign o_rowAddr = r_rowAddr;
   assign o_rowData = r_rowData;

endmodule

// File: rtl/gal_fuse_loader.sv
// ----------------------------------------------------------------------------
// gal_fuse_loader
// Loads a JEDEC fuse stream into the GAL product-term table. It latches the
// two OLMC mode fuses, checks the 16-bit byte-sum checksum and reports the
// result.
//   C, R_N     clock and asynchronous active-low reset
//   START      one-cycle pulse that restarts a load from scratch
//   S          fuse byte stream (slave side)
//   CK_VALID   load CK_DATA as the expected checksum
//   CK_DATA    expected checksum
//   ROW_WE     one-cycle row write strobe, with ROW_ADDR and ROW_DATA
//   MODE       [0] REGISTERED, [1] INVERTED
//   DONE, ERR  held result levels
//   ERR_CODE   reason for ERR (short, long, checksum)
// ----------------------------------------------------------------------------
module gal_fuse_loader
   import gal_cfg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     C,
   input  logic                     R_N,
   input  logic                     START,
   gal_fuse_loader_if.slave         S,
   input  logic                     CK_VALID,
   input  logic [15:0]              CK_DATA,
   output logic                     ROW_WE,
   output logic [$clog2(DEPTH)-1:0] ROW_ADDR,
   output logic [2*WIDTH-1:0]       ROW_DATA,
   output logic [1:0]               MODE,
   output logic                     DONE,
   output logic                     ERR,
   output logic [1:0]               ERR_CODE
);

   localparam int NF  = nfuse(WIDTH, DEPTH);
   localparam int NB  = nbytes(WIDTH, DEPTH);
   localparam int BCW = $clog2(NB + 1);

   localparam int         M0_BYTE = (NF - 2) / 8;
   localparam logic [2:0] M0_BIT  = 3'((NF - 2) % 8);
   localparam int         M1_BYTE = (NF - 1) / 8;
   localparam logic [2:0] M1_BIT  = 3'((NF - 1) % 8);

   state_t           r_state;
   state_t           w_nextState;
   logic [BCW-1:0]   r_byteCnt;
   logic [15:0]      r_sum;
   logic [15:0]      r_ck;
   logic [1:0]       r_mode;
   logic [1:0]       r_errCode;

   logic             w_sReady;
   logic             w_accept;
   logic [BCW-1:0]   w_byteNext;
   logic             w_failSet;
   logic [1:0]       w_failCode;

   // The loader takes bytes only in LOAD. A byte that arrives in the same
   // cycle as START completes the handshake, but the loader drops it because
   // START wipes all progress at that edge.
   assign w_sReady   = (r_state == ST_LOAD);
   assign w_accept   = S.S_VALID & w_sReady & ~START;
   assign w_byteNext = r_byteCnt + BCW'(1);

   // State register.
   always_ff @(posedge C or negedge R_N) begin
      if (!R_N) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. The length checks run only on accepted bytes, so the
   // byte count can never pass NB. CHECK lasts one cycle and compares against
   // the checksum register, which may have been loaded on the final
   // handshake edge.
   always_comb begin
      w_nextState = r_state;
      w_failSet   = 1'b0;
      w_failCode  = ERR_NONE;
      if (START) begin
         w_nextState = ST_LOAD;
      end else begin
         case (r_state)
            ST_LOAD: begin
               if (w_accept) begin
                  if (w_byteNext == BCW'(NB)) begin
                     if (S.S_LAST) begin
                        w_nextState = ST_CHECK;
                     end else begin
                        w_nextState = ST_FAIL;
                        w_failSet   = 1'b1;
                        w_failCode  = ERR_LONG;
                     end
                  end else if (S.S_LAST) begin
                     w_nextState = ST_FAIL;
                     w_failSet   = 1'b1;
                     w_failCode  = ERR_SHORT;
                  end
               end
            end
            ST_CHECK: begin
               if (r_sum == r_ck) begin
                  w_nextState = ST_OK;
               end else begin
                  w_nextState = ST_FAIL;
                  w_failSet   = 1'b1;
                  w_failCode  = ERR_CKSUM;
               end
            end
            default: begin
               w_nextState = r_state;
            end
         endcase
      end
   end

   // Per-load progress: byte count, running sum, mode fuses and error code.
   // Pad bits are part of the sum. The loader takes each mode fuse from
   // whichever byte holds it, and that can be a different byte for each
   // fuse.
   always_ff @(posedge C or negedge R_N) begin
      if (!R_N) begin
         r_byteCnt <= '0;
         r_sum     <= '0;
         r_mode    <= '0;
         r_errCode <= ERR_NONE;
      end else if (START) begin
         r_byteCnt <= '0;
         r_sum     <= '0;
         r_mode    <= '0;
         r_errCode <= ERR_NONE;
      end else begin
         if (w_accept) begin
            r_byteCnt <= w_byteNext;
            r_sum     <= r_sum + {8'h00, S.S_DATA};
            if (r_byteCnt == BCW'(M0_BYTE)) begin
               r_mode[0] <= S.S_DATA[M0_BIT];
            end
            if (r_byteCnt == BCW'(M1_BYTE)) begin
               r_mode[1] <= S.S_DATA[M1_BIT];
            end
         end
         if (w_failSet) begin
            r_errCode <= w_failCode;
         end
      end
   end

   // The expected checksum lives outside the load progress. A restart does
   // not clear it, so the programmer can supply it before or during a load.
   always_ff @(posedge C or negedge R_N) begin
      if (!R_N) begin
         r_ck <= 16'h0000;
      end else if (CK_VALID) begin
         r_ck <= CK_DATA;
      end
   end

   gal_fuse_rowbuf #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_rowbuf (
      .clk       (C),
      .rst_n     (R_N),
      .i_clear   (START),
      .i_push    (w_accept),
      .i_data    (S.S_DATA),
      .o_rowWe   (ROW_WE),
      .o_rowAddr (ROW_ADDR),
      .o_rowData (ROW_DATA)
   );

   assign S.S_READY = w_sReady;
   assign MODE      = r_mode;
   assign DONE      = (r_state == ST_OK);
   assign ERR       = (r_state == ST_FAIL);
   assign ERR_CODE  = r_errCode;

endmodule

// File: tb/tb_gal_fuse_loader.sv
// ----------------------------------------------------------------------------
// tb_gal_fuse_loader
// Drives two loaders: the default 8x8 array and a 5x4 array. It predicts rows,
// mode fuses, checksum outcome and error codes from the JEDEC fuse numbering
// applied to the bytes it sent.
// ----------------------------------------------------------------------------
module tb_gal_fuse_loader;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } rowRec_t;

   logic        C = 1'b0;
   logic        R_N;
   logic        startS [2];
   logic        vld    [2];
   logic        lst    [2];
   logic        ckv    [2];
   logic [7:0]  dat    [2];
   logic [15:0] ckd    [2];

   logic        rowWeA, doneA, errA;
   logic [2:0]  rowAddrA;
   logic [15:0] rowDataA;
   logic [1:0]  modeA, codeA;
   logic        rowWeB, doneB, errB;
   logic [1:0]  rowAddrB;
   logic [9:0]  rowDataB;
   logic [1:0]  modeB, codeB;

   logic        sReady  [2];
   logic        rowWe   [2];
   logic        done    [2];
   logic        err     [2];
   logic [31:0] rowAddr [2];
   logic [31:0] rowData [2];
   logic [1:0]  mode    [2];
   logic [1:0]  code    [2];

   logic [7:0]  strm [0:31];
   rowRec_t     rows0 [$];
   rowRec_t     rows1 [$];
   int          nCompared   = 0;
   int          nMismatched = 0;

   gal_fuse_loader_if ifA ();
   gal_fuse_loader_if ifB ();

   assign ifA.S_VALID = vld[0];
   assign ifA.S_DATA  = dat[0];
   assign ifA.S_LAST  = lst[0];
   assign ifB.S_VALID = vld[1];
   assign ifB.S_DATA  = dat[1];
   assign ifB.S_LAST  = lst[1];

   gal_fuse_loader #(.WIDTH(8), .DEPTH(8)) dutA (
      .C (C), .R_N (R_N), .START (startS[0]), .S (ifA.slave),
      .CK_VALID (ckv[0]), .CK_DATA (ckd[0]),
      .ROW_WE (rowWeA), .ROW_ADDR (rowAddrA), .ROW_DATA (rowDataA),
      .MODE (modeA), .DONE (doneA), .ERR (errA), .ERR_CODE (codeA)
   );

   gal_fuse_loader #(.WIDTH(5), .DEPTH(4)) dutB (
      .C (C), .R_N (R_N), .START (startS[1]), .S (ifB.slave),
      .CK_VALID (ckv[1]), .CK_DATA (ckd[1]),
      .ROW_WE (rowWeB), .ROW_ADDR (rowAddrB), .ROW_DATA (rowDataB),
      .MODE (modeB), .DONE (doneB), .ERR (errB), .ERR_CODE (codeB)
   );

   assign sReady[0]  = ifA.S_READY;
   assign sReady[1]  = ifB.S_READY;
   assign rowWe[0]   = rowWeA;
   assign rowWe[1]   = rowWeB;
   assign done[0]    = doneA;
   assign done[1]    = doneB;
   assign err[0]     = errA;
   assign err[1]     = errB;
   assign rowAddr[0] = 32'(rowAddrA);
   assign rowAddr[1] = 32'(rowAddrB);
   assign rowData[0] = 32'(rowDataA);
   assign rowData[1] = 32'(rowDataB);
   assign mode[0]    = modeA;
   assign mode[1]    = modeB;
   assign code[0]    = codeA;
   assign code[1]    = codeB;

   // Free-running clock with a 10 ns period.
   always #5 C = ~C;

   // Record every row write, sampling on the falling edge.
   always @(negedge C) begin
      if (rowWe[0] === 1'b1) rows0.push_back({rowAddr[0], rowData[0]});
      if (rowWe[1] === 1'b1) rows1.push_back({rowAddr[1], rowData[1]});
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: time limit reached, observed hang expected finish");
      $fatal(1, "[TB] watchdog");
   end

   function automatic int wOf(input int sel);
      return (sel == 0) ? 8 : 5;
   endfunction

   function automatic int dOf(input int sel);
      return (sel == 0) ? 8 : 4;
   endfunction

   function automatic int nbOf(input int sel);
      return (2 * wOf(sel) * dOf(sel) + 2 + 7) / 8;
   endfunction

   function automatic logic fuseAt(input int n);
      logic [7:0] b;
      b = strm[n / 8];
      return b[n % 8];
   endfunction

   function automatic logic [31:0] modelRow(input int w, input int r);
      logic [31:0] v;
      v = '0;
      for (int k = 0; k < 2 * w; k++) v[k] = fuseAt(r * 2 * w + k);
      return v;
   endfunction

   function automatic logic [15:0] modelSum(input int n);
      int s;
      s = 0;
      for (int i = 0; i < n; i++) s += int'(strm[i]);
      return 16'(s);
   endfunction

   function automatic logic [1:0] modelMode(input int sel, input int consumed);
      int  nf;
      logic b0, b1;
      nf = 2 * wOf(sel) * dOf(sel) + 2;
      b0 = ((nf - 2) / 8 < consumed) ? fuseAt(nf - 2) : 1'b0;
      b1 = ((nf - 1) / 8 < consumed) ? fuseAt(nf - 1) : 1'b0;
      return {b1, b0};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      nCompared++;
      assert (obs === expv) else begin
         nMismatched++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic checkIdle(input int sel, input string pfx);
      checkOutput({pfx, ".sReady"},  32'(sReady[sel]), 32'd0);
      checkOutput({pfx, ".rowWe"},   32'(rowWe[sel]),  32'd0);
      checkOutput({pfx, ".rowAddr"}, rowAddr[sel],     32'd0);
      checkOutput({pfx, ".rowData"}, rowData[sel],     32'd0);
      checkOutput({pfx, ".mode"},    32'(mode[sel]),   32'd0);
      checkOutput({pfx, ".done"},    32'(done[sel]),   32'd0);
      checkOutput({pfx, ".err"},     32'(err[sel]),    32'd0);
      checkOutput({pfx, ".errCode"}, 32'(code[sel]),   32'd0);
   endtask

   task automatic loadCk(input int sel, input logic [15:0] v);
      ckv[sel] = 1'b1;
      ckd[sel] = v;
      @(posedge C); #1;
      ckv[sel] = 1'b0;
   endtask

   task automatic pulseStart(input int sel);
      startS[sel] = 1'b1;
      @(posedge C); #1;
      startS[sel] = 1'b0;
      if (sel == 0) rows0.delete(); else rows1.delete();
   endtask

   task automatic sendByte(input int sel, input logic [7:0] d, input logic last,
                           input int gap, output logic accepted);
      repeat (gap) begin @(posedge C); #1; end
      vld[sel] = 1'b1;
      dat[sel] = d;
      lst[sel] = last;
      @(negedge C);
      accepted = sReady[sel];
      @(posedge C); #1;
      vld[sel] = 1'b0;
      lst[sel] = 1'b0;
   endtask

   task automatic sendStream(input int sel, input int n, input int lastAt,
                             input bit gaps, output int nAcc);
      logic acc;
      int   gap;
      nAcc = 0;
      for (int i = 0; i < n; i++) begin
         gap = gaps ? int'($urandom_range(0, 2)) : 0;
         sendByte(sel, strm[i], (i + 1 == lastAt), gap, acc);
         if (acc) nAcc++;
      end
   endtask

   task automatic applyStimulus(input int sel, input int n, input int lastAt,
                                input logic [15:0] ck, input bit gaps, output int nAcc);
      loadCk(sel, ck);
      pulseStart(sel);
      sendStream(sel, n, lastAt, gaps, nAcc);
   endtask

   task automatic verifyRun(input int sel, input int consumed, input int expCode, input string pfx);
      int      nExp, nGot;
      rowRec_t r;
      repeat (3) begin @(posedge C); #1; end
      nExp = (8 * consumed) / (2 * wOf(sel));
      if (nExp > dOf(sel)) nExp = dOf(sel);
      nGot = (sel == 0) ? rows0.size() : rows1.size();
      checkOutput({pfx, ".rowCount"}, 32'(nGot), 32'(nExp));
      for (int i = 0; i < nGot && i < nExp; i++) begin
         r = (sel == 0) ? rows0[i] : rows1[i];
         checkOutput({pfx, ".rowAddr"}, r.addr, 32'(i));
         checkOutput({pfx, ".rowData"}, r.data, modelRow(wOf(sel), i));
      end
      checkOutput({pfx, ".done"},    32'(done[sel]), 32'(expCode == 0));
      checkOutput({pfx, ".err"},     32'(err[sel]),  32'(expCode != 0));
      checkOutput({pfx, ".errCode"}, 32'(code[sel]), 32'(expCode));
      checkOutput({pfx, ".mode"},    32'(mode[sel]), 32'(modelMode(sel, consumed)));
      checkOutput({pfx, ".sReady"},  32'(sReady[sel]), 32'd0);
   endtask

   task automatic fillCount(input int n);
      for (int i = 0; i < n; i++) strm[i] = 8'(i + 1);
   endtask

   initial begin
      int   nAcc, sel, scen, nb, lastAt, nSend, consumed, expCode;
      logic [15:0] ck;
      logic acc;

      for (int s = 0; s < 2; s++) begin
         startS[s] = 1'b0; vld[s] = 1'b0; lst[s] = 1'b0;
         ckv[s] = 1'b0; dat[s] = 8'h00; ckd[s] = 16'h0000;
      end
      R_N = 1'b0;
      #12;
      checkIdle(0, "rstA");
      checkIdle(1, "rstB");
      R_N = 1'b1;
      @(posedge C); #1;

      $display("[TB] good stream 0x01..0x11, checksum 0x0099");
      fillCount(17);
      applyStimulus(0, 17, 17, 16'h0099, 1'b0, nAcc);
      checkOutput("t1.accepted", 32'(nAcc), 32'd17);
      checkOutput("t1.doneInCheck", 32'(done[0]), 32'd0);
      checkOutput("t1.modeAfterLast", 32'(mode[0]), 32'd1);
      @(posedge C); #1;
      checkOutput("t1.doneTiming", 32'(done[0]), 32'd1);
      verifyRun(0, 17, 0, "t1");
      checkOutput("t1.row0", (rows0.size() == 8) ? rows0[0].data : 32'hDEAD, 32'h0201);
      checkOutput("t1.row7", (rows0.size() == 8) ? rows0[7].data : 32'hDEAD, 32'h100F);

      $display("[TB] same stream, checksum 0x0098");
      applyStimulus(0, 17, 17, 16'h0098, 1'b0, nAcc);
      verifyRun(0, 17, 3, "t2");

      $display("[TB] S_LAST on byte 10");
      applyStimulus(0, 10, 10, 16'h0099, 1'b0, nAcc);
      verifyRun(0, 10, 1, "t3");

      $display("[TB] 17 bytes without S_LAST");
      applyStimulus(0, 17, 0, 16'h0099, 1'b0, nAcc);
      verifyRun(0, 17, 2, "t4");
      sendByte(0, 8'h55, 1'b0, 0, acc);
      checkOutput("t4.byte18Accepted", 32'(acc), 32'd0);

      $display("[TB] restart after byte 6, restart on a handshake");
      for (int i = 0; i < 17; i++) strm[i] = 8'($urandom);
      applyStimulus(0, 6, 0, 16'h0000, 1'b0, nAcc);
      fillCount(17);
      loadCk(0, 16'h0099);
      vld[0] = 1'b1; dat[0] = 8'hAA; startS[0] = 1'b1;
      @(negedge C);
      checkOutput("t5.readyOnStart", 32'(sReady[0]), 32'd1);
      @(posedge C); #1;
      vld[0] = 1'b0; startS[0] = 1'b0;
      rows0.delete();
      sendStream(0, 17, 17, 1'b0, nAcc);
      verifyRun(0, 17, 0, "t5");

      $display("[TB] 5x4 array, 0xFF x6, checksum 0x05FA");
      for (int i = 0; i < 6; i++) strm[i] = 8'hFF;
      applyStimulus(1, 6, 6, 16'h05FA, 1'b0, nAcc);
      verifyRun(1, 6, 0, "t6");
      checkOutput("t6.row3", (rows1.size() == 4) ? rows1[3].data : 32'hDEAD, 32'h3FF);
      checkOutput("t6.modeConst", 32'(mode[1]), 32'd3);

      $display("[TB] randomized streams");
      for (int it = 0; it < 10; it++) begin
         sel  = it % 2;
         nb   = nbOf(sel);
         scen = int'($urandom_range(0, 3));
         for (int i = 0; i < nb; i++) strm[i] = 8'($urandom);
         ck = 16'($urandom);
         if (scen == 0) ck = modelSum(nb);
         if (scen == 1) ck = modelSum(nb) ^ 16'($urandom_range(1, 65535));
         lastAt = (scen == 2) ? int'($urandom_range(1, nb - 1)) : ((scen == 3) ? 0 : nb);
         nSend  = (lastAt == 0) ? nb : lastAt;
         if (lastAt != 0 && lastAt < nb) begin
            consumed = lastAt; expCode = 1;
         end else if (lastAt == 0) begin
            consumed = nb; expCode = 2;
         end else begin
            consumed = nb; expCode = (modelSum(nb) == ck) ? 0 : 3;
         end
         applyStimulus(sel, nSend, lastAt, ck, 1'b1, nAcc);
         checkOutput("rnd.accepted", 32'(nAcc), 32'(nSend));
         verifyRun(sel, consumed, expCode, "rnd");
      end

      $display("[TB] asynchronous reset in the middle of a load");
      fillCount(17);
      applyStimulus(0, 17, 17, 16'h0099, 1'b0, nAcc);
      verifyRun(0, 17, 0, "t7");
      strm[0] = 8'hFF; strm[1] = 8'hFF;
      applyStimulus(1, 2, 0, 16'h0000, 1'b0, nAcc);
      checkOutput("t7.rowWePending", 32'(rowWe[1]), 32'd1);
      #2;
      R_N = 1'b0;
      #1;
      checkIdle(0, "t7.rstA");
      checkIdle(1, "t7.rstB");
      @(negedge C);
      R_N = 1'b1;
      @(posedge C); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
